// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction size and the NOP
// encoding placed on the IF/ID register when it holds no live instruction.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_BUFFERED
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/adder_64.sv
// 64-bit ripple-carry adder; the carry out is discarded, so results wrap silently.
module adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction memory
// port and fills the IF/ID register, with a one-entry skid buffer for stalls.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [63:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_base,
  input  logic [63:0]        redirect_offset,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [63:0]        out_pc,
  output logic [63:0]        out_pc_plus4
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  fetch_state_t       state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        pending_pc_q, pending_pc_d;
  logic               discard_q, discard_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [63:0]        out_pc_q, out_pc_d;
  logic [63:0]        out_pc4_q, out_pc4_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [63:0]        skid_pc_q, skid_pc_d;
  logic [63:0]        skid_pc4_q, skid_pc4_d;

  logic [63:0] pc_inc;
  logic [63:0] offset_shifted;
  logic [63:0] target;
  logic        slot_free;

  assign offset_shifted = redirect_offset << 2;

  adder_64 u_pc_inc (
    .a   (pc_q),
    .b   (64'(INSTR_BYTES)),
    .sum (pc_inc)
  );

  adder_64 u_target (
    .a   (redirect_base),
    .b   (offset_shifted),
    .sum (target)
  );

  assign slot_free    = !out_valid_q || !stall;
  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc4_q;

  // Redirect beats ack and stall; an in-flight request cannot be cancelled,
  // so its data is dropped and the target waits in pending_pc.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    discard_d    = discard_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          out_instr_d = NOP;
          if (imem_ack) begin
            pc_d      = target;
            discard_d = 1'b0;
          end else begin
            pending_pc_d = target;
            discard_d    = 1'b1;
          end
        end else begin
          if (slot_free) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP;
          end
          if (imem_ack && discard_q) begin
            pc_d      = pending_pc_q;
            discard_d = 1'b0;
          end else if (imem_ack) begin
            pc_d = pc_inc;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_instr_d = imem_rdata;
              out_pc_d    = pc_q;
              out_pc4_d   = pc_inc;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              skid_pc4_d   = pc_inc;
              state_d      = S_BUFFERED;
            end
          end
        end
      end

      S_BUFFERED: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          out_instr_d = NOP;
          pc_d        = target;
          state_d     = S_FETCH;
        end else if (slot_free) begin
          out_valid_d = 1'b1;
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          out_pc4_d   = skid_pc4_q;
          state_d     = S_FETCH;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      discard_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_pc4_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      discard_q    <= discard_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined CPU. It holds the 64-bit program counter and drives a request/acknowledge instruction-memory port. It delivers fetched instructions into the IF/ID pipeline register. PC+4 and branch targets are computed with the existing 64-bit ripple adder; redirects come from the branch-resolution stage downstream.

## Interface

Parameters:
- RESET_PC, 64'h0 — PC value after reset.
- INSTR_W, 32 — instruction width.

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- imem_req  out  1  — fetch request; held high until imem_ack.
- imem_addr  out  64  — fetch address; stable while imem_req is high.
- imem_ack  in  1  — memory returns imem_rdata this cycle; latency 1..N cycles after req.
- imem_rdata  in  INSTR_W  — instruction word, valid only with imem_ack.
- stall  in  1  — ID stage cannot accept; IF/ID register holds.
- redirect_valid  in  1  — taken branch/jump; flush and refetch.
- redirect_base  in  64  — PC of the branch instruction.
- redirect_offset  in  64  — sign-extended word offset; block shifts left by 2.
- out_valid  out  1  — IF/ID register holds a live instruction.
- out_instr  out  INSTR_W  — fetched instruction.
- out_pc  out  64  — PC of out_instr.
- out_pc_plus4  out  64  — out_pc + 4.

## Operation

- States: S_RESET, S_FETCH, S_BUFFERED.
  - S_RESET: entered on reset. Moves to S_FETCH on the first edge after reset_n rises.
  - S_FETCH: imem_req=1, imem_addr=pc. On imem_ack the instruction is routed as follows.
    - If the output slot is free (!out_valid || !stall), it is loaded into IF/ID and pc ← pc+4.
    - Otherwise it is captured into a one-entry skid buffer, pc ← pc+4, and the state moves to S_BUFFERED.
  - S_BUFFERED: imem_req=0. When stall=0, the skid entry moves into IF/ID and the state returns to S_FETCH.
- Redirect target = redirect_base + (redirect_offset << 2), computed by an adder_64 instance. The shift discards the upper 2 bits.
- On redirect_valid, from any state other than S_RESET:
  - out_valid ← 0 and the skid buffer is cleared.
  - No request outstanding (no req, or ack this cycle): pc ← target, state S_FETCH, and the ack data, if any, is dropped.
  - Request outstanding without ack: imem_addr stays unchanged and req stays high. The target is latched into pending_pc and discard ← 1. The returning ack data is dropped, and then pc ← pending_pc.
  - A second redirect while discard=1 overwrites pending_pc.
- Redirect has priority over stall and over ack.
- IF/ID register: loads when (!stall || !out_valid). When stall=1 and out_valid=1 it holds all outputs unchanged.
- pc+4 is computed by a second adder_64 instance. 64-bit wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is silent.

## Timing

- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, pc=RESET_PC, discard=0.
- First imem_req is high in the cycle after the first edge with reset_n=1.
- Ack in cycle T: out_valid=1 from T+1, when the slot is free. The next request's imem_addr=pc+4 appears in T+1.
- Zero-bubble throughput is 1 instruction/cycle when ack is combinational in the same cycle as req.
- Redirect in cycle T with no outstanding request: imem_addr=target in T+1.
- reset_n low mid-transaction clears all state immediately. A late ack after reset is ignored, because req=0 in S_RESET.

## Structure

- Shared package cpu_pkg holds:
  - fetch_state_t enum (S_RESET, S_FETCH, S_BUFFERED);
  - INSTR_BYTES constant = 4;
  - the NOP encoding, used for out_instr when not valid.
- Sub-modules: two instances of the existing adder_64, one for pc+4 and one for the redirect target.
- Registered: IF/ID, skid buffer, pc, pending_pc, discard.

## Test plan

- Reset with RESET_PC=64'h100, ack one cycle after each req, stall=0 → imem_addr sequence 100,104,108. out_pc follows one cycle later with out_pc_plus4=out_pc+4.
- stall=1 for 3 cycles while out_valid=1 and an ack arrives → that instruction is held in the skid buffer and imem_req=0. On stall release, out_instr updates in order and no instruction is lost or duplicated.
- redirect_valid with base=64'h200, offset=-2, and no outstanding request → next imem_addr=64'h1F8 and out_valid=0 in the following cycle.
- Redirect asserted while a request to 64'h108 awaits ack with 3-cycle latency → imem_addr stays 108 until ack. The data is dropped (out_valid stays 0), and the next req is to the target.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetch → next imem_addr=0, no X on any output.
- reset_n pulsed low during an outstanding request → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
